adder_arbiter: RTL

Round-robin arbiter and sequencer that shares one WIDTH-bit adder between N_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. One pair per cycle is granted, added and registered. The registered result, tagged with the requester index, goes to a single downstream consumer through a valid/ready handshake with back-pressure. The block sits between the pin-level operand sources and the shared adder datapath in the tile top level.

---
 rtl/adder_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder between N_REQ requesters
// and registers each tagged sum for a single back-pressured consumer.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_ready
);

  logic             run;
  logic [IDW-1:0]   ptr;
  logic             slot_free;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic             found;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;

  assign slot_free = !res_valid || res_ready;

  // N_REQ is a power of two, so IDW-bit addition wraps the search naturally.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    if (run && ena && slot_free) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = ptr + IDW'(k);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;

  // Operands are picked by the one-hot grant so the select uses constant slices.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        a_sel = req_a[k*WIDTH +: WIDTH];
        b_sel = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      ptr       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else begin
      run <= 1'b1;
      if (found) begin
        res_valid <= 1'b1;
        res_sum   <= sum_full[WIDTH-1:0];
        res_carry <= sum_full[WIDTH];
        res_id    <= grant_id;
        ptr       <= grant_id + IDW'(1);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
